// File: rtl/max_q_select_fp.sv
// -----------------------------------------------------------------------------
// max_q_select_fp
//
// Sequential max-Q selector. After an accepted start it collects N_ACTIONS
// IEEE-754 single-precision Q-values (one per in_valid cycle) and reports the
// largest value together with its 0-based arrival index. The compare is a
// sign-magnitude compare with no adder. NaNs never win, except that an all-NaN
// set returns sample 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a new selection, accepted only in IDLE
//   in_valid   in   in_q carries a Q-value this cycle (used only in COLLECT)
//   in_q       in   [31:0] IEEE-754 single Q-value
//   busy       out  high from the cycle after an accepted start through the
//                   out_valid cycle
//   out_valid  out  one-cycle pulse; out_max/out_idx are final
//   out_max    out  [31:0] largest Q-value of the set
//   out_idx    out  [IDX_W-1:0] arrival index of out_max
// -----------------------------------------------------------------------------
module max_q_select_fp #(
    parameter int N_ACTIONS = 4,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [31:0]      in_q,
    output logic             busy,
    output logic             out_valid,
    output logic [31:0]      out_max,
    output logic [IDX_W-1:0] out_idx
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ACTIONS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_count;
    logic [31:0]      r_best_q;
    logic [IDX_W-1:0] r_best_idx;

    logic w_accept;
    logic w_last;
    logic w_take;

    // Exponent all ones with a non-zero mantissa.
    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // a > b for non-NaN operands; +0 and -0 compare equal.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return !a[31] && ((a[30:0] != 31'd0) || (b[30:0] != 31'd0));
        else if (!a[31])
            return a[30:0] > b[30:0];
        else
            return a[30:0] < b[30:0];
    endfunction

    assign w_accept = (r_state == COLLECT) && in_valid;
    assign w_last   = w_accept && (r_count == LAST_IDX);

    // Sample 0 always loads. Later samples win only if strictly greater; a
    // NaN never wins, and a NaN sitting in best (only possible from sample 0)
    // loses to any real value. Ties keep the lower index.
    assign w_take = w_accept &&
                    ((r_count == '0) ||
                     (!is_nan(in_q) && (is_nan(r_best_q) || fp_gt(in_q, r_best_q))));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of latches
    // on paths that do not mention w_state_nxt.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start)  w_state_nxt = COLLECT;
            COLLECT: if (w_last) w_state_nxt = DONE;
            DONE:                w_state_nxt = IDLE;
            default:             w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_count <= '0;
        end else if (w_accept) begin
            // Wraps to 0 after the last sample; it is cleared on start anyway.
            r_count <= r_count + IDX_W'(1);
        end
    end

    // The best registers double as the output holding registers: they change
    // only on accepted samples, so the result holds until the next set's
    // first sample arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_q   <= 32'h0;
            r_best_idx <= '0;
        end else if (w_take) begin
            r_best_q   <= in_q;
            r_best_idx <= r_count;
        end
    end

    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign out_max   = r_best_q;
    assign out_idx   = r_best_idx;

endmodule

// File: tb/tb_max_q_select_fp.sv
// -----------------------------------------------------------------------------
// tb_max_q_select_fp
//
// Directed testbench for max_q_select_fp (N_ACTIONS=4). Inputs change 1 ns
// after a rising edge and outputs are sampled at the same point, so each
// sample reflects the state entered on the preceding edge.
// -----------------------------------------------------------------------------
module tb_max_q_select_fp;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [31:0] in_q;
    logic        busy;
    logic        out_valid;
    logic [31:0] out_max;
    logic [1:0]  out_idx;

    int n_checks = 0;
    int n_pass   = 0;

    max_q_select_fp #(
        .N_ACTIONS(4),
        .IDX_W    (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_q     (in_q),
        .busy     (busy),
        .out_valid(out_valid),
        .out_max  (out_max),
        .out_idx  (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start, then four samples with 'gap' idle cycles between them.
    // During gaps in_q carries +inf and start is pulsed; both must be ignored.
    // With junk=1, in_valid=1/+inf is also driven on the start cycle.
    // Returns in the cycle where out_valid is expected.
    task automatic drive_set(input logic [31:0] q0, input logic [31:0] q1,
                             input logic [31:0] q2, input logic [31:0] q3,
                             input int gap, input bit junk,
                             output bit busy_ok, output bit early_valid);
        logic [31:0] q [4];
        q[0] = q0; q[1] = q1; q[2] = q2; q[3] = q3;
        busy_ok     = 1'b1;
        early_valid = 1'b0;
        start    = 1'b1;
        in_valid = junk;
        in_q     = 32'h7F800000;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        if (!busy)    busy_ok     = 1'b0;
        if (out_valid) early_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_q     = q[i];
            tick();
            in_valid = 1'b0;
            in_q     = 32'h7F800000;
            if (i < 3) begin
                if (!busy)     busy_ok     = 1'b0;
                if (out_valid) early_valid = 1'b1;
                for (int g = 0; g < gap; g++) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                    if (!busy)     busy_ok     = 1'b0;
                    if (out_valid) early_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_q     = 32'h0;
        #2;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_max !== 32'h0) $display("FAIL reset_out_max: got %h expected 00000000", out_max);
        else n_pass++;
        n_checks++;
        if (out_idx !== 2'd0) $display("FAIL reset_out_idx: got %0d expected 0", out_idx);
        else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ascending();
        bit busy_ok, early;
        drive_set(32'h3F000000, 32'h3F800000, 32'h40000000, 32'hBF800000, 0, 1'b0, busy_ok, early);
        n_checks++;
        if (!busy_ok) $display("FAIL asc_busy_during: got busy low expected high");
        else n_pass++;
        n_checks++;
        if (early) $display("FAIL asc_early_valid: got out_valid before t+5 expected none");
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL asc_valid_t5: got valid=%b busy=%b expected 1 1", out_valid, busy);
        else n_pass++;
        n_checks++;
        if (out_max !== 32'h40000000) $display("FAIL asc_max: got %h expected 40000000", out_max);
        else n_pass++;
        n_checks++;
        if (out_idx !== 2'd2) $display("FAIL asc_idx: got %0d expected 2", out_idx);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL asc_after: got valid=%b busy=%b expected 0 0", out_valid, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (out_max !== 32'h40000000 || out_idx !== 2'd2)
            $display("FAIL asc_hold: got %h/%0d expected 40000000/2", out_max, out_idx);
        else n_pass++;
    endtask

    typedef struct {
        string       name;
        logic [31:0] q0, q1, q2, q3;
        logic [31:0] emax;
        logic [1:0]  eidx;
    } vec_t;

    task automatic test_value_sets();
        vec_t v [7];
        bit   busy_ok, early;
        v[0] = '{"all_neg",  32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC0800000, 32'hBF800000, 2'd1};
        v[1] = '{"tie_pos",  32'h3F800000, 32'h3F800000, 32'h00000000, 32'h80000000, 32'h3F800000, 2'd0};
        v[2] = '{"zeros",    32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000, 2'd0};
        v[3] = '{"nan",      32'h7FC00000, 32'hBF800000, 32'h7FC00000, 32'hC0000000, 32'hBF800000, 2'd1};
        v[4] = '{"all_nan",  32'hFFC00000, 32'h7FC00000, 32'h7F800001, 32'hFFFFFFFF, 32'hFFC00000, 2'd0};
        v[5] = '{"inf",      32'hFF800000, 32'h7F7FFFFF, 32'h00000001, 32'h7F800000, 32'h7F800000, 2'd3};
        v[6] = '{"neg_zero", 32'hC0000000, 32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000, 2'd1};
        for (int k = 0; k < 7; k++) begin
            drive_set(v[k].q0, v[k].q1, v[k].q2, v[k].q3, 0, 1'b0, busy_ok, early);
            n_checks++;
            if (out_valid !== 1'b1 || early)
                $display("FAIL %s_valid: got valid=%b early=%b expected 1 0", v[k].name, out_valid, early);
            else n_pass++;
            n_checks++;
            if (out_max !== v[k].emax)
                $display("FAIL %s_max: got %h expected %h", v[k].name, out_max, v[k].emax);
            else n_pass++;
            n_checks++;
            if (out_idx !== v[k].eidx)
                $display("FAIL %s_idx: got %0d expected %0d", v[k].name, out_idx, v[k].eidx);
            else n_pass++;
            tick();
            n_checks++;
            if (out_valid !== 1'b0)
                $display("FAIL %s_pulse_width: got %b expected 0", v[k].name, out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_stalls();
        bit busy_ok, early;
        drive_set(32'h3F000000, 32'h3F800000, 32'h40000000, 32'hBF800000, 2, 1'b0, busy_ok, early);
        n_checks++;
        if (!busy_ok) $display("FAIL stall_busy: got busy low in a gap expected high");
        else n_pass++;
        n_checks++;
        if (early) $display("FAIL stall_early_valid: got early out_valid expected none");
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || out_max !== 32'h40000000 || out_idx !== 2'd2)
            $display("FAIL stall_result: got v=%b %h/%0d expected 1 40000000/2", out_valid, out_max, out_idx);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL stall_after: got valid=%b busy=%b expected 0 0", out_valid, busy);
        else n_pass++;
    endtask

    task automatic test_idle_controls();
        bit busy_ok, early;
        in_valid = 1'b1;
        in_q     = 32'h7F800000;
        tick();
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL idle_in_valid: got busy=%b valid=%b expected 0 0", busy, out_valid);
        else n_pass++;
        drive_set(32'h3F000000, 32'h3F800000, 32'h40000000, 32'hBF800000, 0, 1'b1, busy_ok, early);
        n_checks++;
        if (out_valid !== 1'b1 || out_max !== 32'h40000000 || out_idx !== 2'd2)
            $display("FAIL idle_junk_result: got v=%b %h/%0d expected 1 40000000/2", out_valid, out_max, out_idx);
        else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL done_start_ignored: got busy=%b valid=%b expected 0 0", busy, out_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL done_start_stays_idle: got busy=%b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit busy_ok, early;
        drive_set(32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC0800000, 0, 1'b0, busy_ok, early);
        n_checks++;
        if (out_valid !== 1'b1 || out_max !== 32'hBF800000 || out_idx !== 2'd1)
            $display("FAIL b2b_first: got v=%b %h/%0d expected 1 BF800000/1", out_valid, out_max, out_idx);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0 || out_max !== 32'hBF800000)
            $display("FAIL b2b_idle_gap: got busy=%b max=%h expected 0 BF800000", busy, out_max);
        else n_pass++;
        drive_set(32'h3F000000, 32'h3F800000, 32'h40000000, 32'hBF800000, 0, 1'b0, busy_ok, early);
        n_checks++;
        if (!busy_ok || early)
            $display("FAIL b2b_second_timing: got busy_ok=%b early=%b expected 1 0", busy_ok, early);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || out_max !== 32'h40000000 || out_idx !== 2'd2)
            $display("FAIL b2b_second: got v=%b %h/%0d expected 1 40000000/2", out_valid, out_max, out_idx);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_abort();
        bit busy_ok, early;
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_q     = 32'h3F800000;
        tick();
        in_q     = 32'h40400000;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_max !== 32'h0 || out_idx !== 2'd0)
            $display("FAIL abort_immediate: got b=%b v=%b %h/%0d expected 0 0 00000000/0",
                     busy, out_valid, out_max, out_idx);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL abort_no_valid: got %b expected 0", out_valid);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        drive_set(32'h3F800000, 32'hBF800000, 32'h3F000000, 32'hC0000000, 0, 1'b0, busy_ok, early);
        n_checks++;
        if (out_valid !== 1'b1 || out_max !== 32'h3F800000 || out_idx !== 2'd0)
            $display("FAIL abort_fresh: got v=%b %h/%0d expected 1 3F800000/0", out_valid, out_max, out_idx);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_value_sets();
        test_stalls();
        test_idle_controls();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
